// File: rtl/regfile_writeback_arbiter_if.sv
// Bus bundle between the writeback sources, the arbiter and the register-file write port.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline's view.
interface regfile_writeback_arbiter_if;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        stall_req;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  ll_valid, ll_rd, ll_data,
    input  issue_valid, issue_rd,
    output ll_ready, busy, stall_req,
    output wr_en, wr_idx, wr_data
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output ll_valid, ll_rd, ll_data,
    output issue_valid, issue_rd,
    input  ll_ready, busy, stall_req,
    input  wr_en, wr_idx, wr_data
  );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Merges pipeline writebacks and a FIFO of long-latency results onto the single register-file write port.
// Define WB_SCOREBOARD_EN to build the pending-destination scoreboard; otherwise busy is tied to zero.
module regfile_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  regfile_writeback_arbiter_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    r_fifo_rd   [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_wait;
  logic          r_wr_en;
  logic [4:0]    r_wr_idx;
  logic [31:0]   r_wr_data;

  logic          w_empty;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;

  // ll_ready comes only from the registered count, so a full FIFO refuses even while popping.
  assign w_empty     = (r_count == '0);
  assign w_ready     = (r_count < CW'(DEPTH));
  assign w_push      = bus.ll_valid && w_ready;
  assign w_pop       = !bus.pipe_valid && !w_empty;
  assign w_head_rd   = r_fifo_rd[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  assign bus.ll_ready  = w_ready;
  assign bus.stall_req = (r_wait >= 8'(STARVE_LIMIT));
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_idx    = r_wr_idx;
  assign bus.wr_data   = r_wr_data;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= bus.ll_rd;
      r_fifo_data[r_wptr] <= bus.ll_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Register 0 is hardwired, so its writes are consumed but never enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
    end else if (bus.pipe_valid) begin
      r_wr_en   <= (bus.pipe_rd != 5'd0);
      r_wr_idx  <= bus.pipe_rd;
      r_wr_data <= bus.pipe_data;
    end else if (w_pop) begin
      r_wr_en   <= (w_head_rd != 5'd0);
      r_wr_idx  <= w_head_rd;
      r_wr_data <= w_head_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_empty || w_pop) begin
      r_wait <= '0;
    end else if (r_wait != 8'hFF) begin
      r_wait <= r_wait + 1'b1;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_busy_next;

  // Clear is applied before set so a same-cycle re-issue keeps the register pending.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop) w_busy_next[w_head_rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) w_busy_next[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next & 32'hFFFF_FFFE;
  end

  assign bus.busy = r_busy;
`else
  logic w_unused_issue;
  assign w_unused_issue = ^{bus.issue_valid, bus.issue_rd};
  assign bus.busy       = 32'b0;
`endif
endmodule
